// File: rtl/rr_arb_mux.sv
// N-to-1 valid/ready multiplexer with an internal round-robin or fixed-priority arbiter.
// The granted word is captured in one output register together with its source index.
module rr_arb_mux #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N       = 4,
    parameter int unsigned IDXW    = $clog2(N),
    parameter int unsigned RR_MODE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDXW-1:0]      out_sel,
    input  logic                 out_ready
);

    localparam int unsigned CW = IDXW + 1;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [IDXW-1:0]      out_sel_q, out_sel_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;

    logic [N-1:0]         grant;
    logic [IDXW-1:0]      gnt_idx;
    logic                 found;
    logic [CW-1:0]        base;
    logic [CW-1:0]        cand;
    logic [WIDTH-1:0]     sel_data;
    logic                 load_en;
    logic                 xfer;

    // Search channels starting at the pointer (0 in fixed-priority mode), wrapping modulo N.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        base    = (RR_MODE != 0) ? CW'(ptr_q) : '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = base + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && in_valid[cand[IDXW-1:0]]) begin
                found                  = 1'b1;
                grant[cand[IDXW-1:0]]  = 1'b1;
                gnt_idx                = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = (load_en && !reset) ? grant : '0;
    assign xfer     = |in_ready;

    // Next-state: refill wins over drain; a stall holds everything.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = gnt_idx;
            if (RR_MODE != 0) begin
                ptr_d = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-to-1 datapath multiplexer that generalises the 32-bit 2:1 select into N valid/ready channels.
- Selection is by an internal arbiter, either round-robin or fixed-priority, instead of an external select line.
- The chosen word is captured in a single output register and presented downstream with its source index.
- Used wherever several producers share one datapath consumer, e.g. multiple request sources feeding one memory or writeback port.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N, 4, number of input channels (N >= 2).
- IDXW, $clog2(N), width of the source index.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  IDXW  registered index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset is synchronous and active-high: on a clk edge with reset=1, out_valid=0, out_data=0, out_sel=0, and the RR pointer=0.
- While reset=1, in_ready=0 on every channel.
- Reset mid-operation discards any buffered word. No transfer completes on a reset cycle.
- load_en = !out_valid || out_ready. The register can take a new word when it is empty or is being drained in the same cycle.
- Grant is combinational and one-hot, chosen among channels with in_valid=1:
  - RR_MODE=1: the first valid channel at or after ptr, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - RR_MODE=0: the lowest-index valid channel; ptr is unused and stays 0.
- in_ready[i] = load_en && grant[i] && !reset. At most one bit is set. in_ready may depend on in_valid.
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. At that clk edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - In RR_MODE, ptr <= (g+1) mod N, wrapping from N-1 to 0.
- Drain with no refill (out_valid && out_ready, no input transfer): out_valid <= 0. out_data and out_sel hold their last values.
- Drain and refill in the same cycle: the new word replaces the old. Sustained throughput is 1 word/clk.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid hold, all in_ready=0, ptr holds.
- Latency: 1 clk from input transfer to out_valid. No combinational path from in_data to out_data.
- No valid inputs: no grant, in_ready=0, ptr unchanged.
- ptr advances only on an actual transfer, never on an idle cycle or a stall.
- A producer holds in_valid and in_data stable until accepted; the block does not check this.
- Simultaneous all-valid with out_ready=1 in RR_MODE: the N channels are served in strict rotation, one per clk.
- Width rules: no arithmetic on data. ptr is IDXW bits with explicit modulo-N wrap, so non-power-of-2 N never yields an index >= N.

Test Plan:
- Reset, then idle: reset=1 for 2 clk with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0; after release with in_valid=0 -> out_valid stays 0.
- Single channel: in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next clk out_valid=1, out_data=32'hDEADBEEF, out_sel=2.
- Round-robin fairness: RR_MODE=1, in_valid=4'b1111 held, channel i data=i+32'h100, out_ready=1 for 8 clk -> out_sel sequence 0,1,2,3,0,1,2,3 with matching data, one word per clk.
- Back-pressure: out_valid=1 with out_sel=1, out_ready=0 for 3 clk, in_valid=4'b1111 -> in_ready=0, output holds; out_ready=1 -> next grant goes to channel 2.
- Fixed priority with wrap: RR_MODE=0, in_valid=4'b1010, out_ready=1 -> channel 1 granted every cycle and channel 3 starves. With N=3, RR_MODE=1 and ptr=2, in_valid=3'b011 -> grant channel 0 and ptr wraps to 1.
- Reset mid-operation: out_valid=1 with out_ready=0, assert reset for 1 clk -> out_valid=0 and ptr=0 next cycle; the first grant after release with in_valid=4'b1111 goes to channel 0.
